// File: rtl/mixed_package.sv
// Shared table-arbiter types: sizing constants, address/entry types and the arbiter state enum.
package mixed_package;

    localparam int TBL_DEPTH  = 10;
    localparam int TBL_ADDR_W = 4;
    localparam int TBL_DATA_W = 64;

    typedef logic [TBL_ADDR_W-1:0] bSizeSt;
    typedef logic [TBL_DATA_W-1:0] bigSt;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } tblArbStateT;

endpackage

// File: rtl/memory_if.sv
// Single-port memory access bundle; read_data is valid the cycle after a read enable.
interface memory_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 64
);
    logic              enable;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (output enable, wr_en, addr, write_data, input read_data);
    modport slave  (input enable, wr_en, addr, write_data, output read_data);
endinterface

// File: rtl/tbl_arb_sat_cnt.sv
// Saturating event counter with synchronous clear (clear wins over increment); 1-cycle update.
// Present only in builds with TBL_ARB_STATS_EN; no backpressure.
`ifdef TBL_ARB_STATS_EN
module tbl_arb_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule
`endif

// File: rtl/blockb_table_arbiter.sv
// Arbitrates table memory: register path (never stalled) > zero-fill init > hw requester; hw read data 1 cycle after grant.
// hw_req is held until hw_gnt; optional TBL_ARB_STATS_EN adds grant/blocked saturating counters.
module blockb_table_arbiter
    import mixed_package::*;
#(
    parameter int DEPTH  = TBL_DEPTH,
    parameter int ADDR_W = TBL_ADDR_W,
    parameter int DATA_W = TBL_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    memory_if.slave           regMem,
    memory_if.master          tblMem,
    input  logic              hw_req,
    input  logic              hw_wr,
    input  logic [ADDR_W-1:0] hw_addr,
    input  logic [DATA_W-1:0] hw_wdata,
    output logic              hw_gnt,
    output logic              hw_err,
    output logic              hw_rvalid,
    output logic [DATA_W-1:0] hw_rdata,
    input  logic              init_req,
    output logic              init_busy
`ifdef TBL_ARB_STATS_EN
    ,
    output logic [15:0]       stat_hw_gnt,
    output logic [15:0]       stat_hw_blocked
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    tblArbStateT       state_q, state_d;
    logic [PTR_W-1:0]  init_ptr_q, init_ptr_d;
    logic              hw_rvalid_q, hw_rvalid_d;
    logic              hw_rerr_q, hw_rerr_d;
    logic [DATA_W-1:0] hw_rdata_q, hw_rdata_d;

    logic              tbl_en;
    logic              tbl_wr;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_wdata;
    logic              addr_oob;

    assign addr_oob = (int'(hw_addr) >= DEPTH);

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        tbl_en     = 1'b0;
        tbl_wr     = 1'b0;
        tbl_addr   = '0;
        tbl_wdata  = '0;
        hw_gnt     = 1'b0;
        hw_err     = 1'b0;

        if (regMem.enable) begin
            tbl_en    = 1'b1;
            tbl_wr    = regMem.wr_en;
            tbl_addr  = regMem.addr;
            tbl_wdata = regMem.write_data;
        end else if (state_q == S_INIT) begin
            tbl_en   = 1'b1;
            tbl_wr   = 1'b1;
            tbl_addr = ADDR_W'(init_ptr_q);
            if (init_ptr_q == LAST_PTR) begin
                state_d = S_RUN;
            end else begin
                init_ptr_d = init_ptr_q + PTR_W'(1);
            end
        end else if (hw_req) begin
            // Out-of-range requests are granted with an error but never reach the memory.
            hw_gnt    = 1'b1;
            hw_err    = addr_oob;
            tbl_en    = ~addr_oob;
            tbl_wr    = hw_wr & ~addr_oob;
            tbl_addr  = hw_addr;
            tbl_wdata = hw_wdata;
        end

        if (init_req) begin
            state_d    = S_INIT;
            init_ptr_d = '0;
        end
    end

    assign hw_rvalid_d = hw_gnt & ~hw_wr;
    assign hw_rerr_d   = hw_err;

    // Memory data arrives the cycle after the read; hold it afterwards so hw_rdata stays stable.
    always_comb begin
        hw_rdata_d = hw_rdata_q;
        if (hw_rvalid_q) begin
            hw_rdata_d = hw_rerr_q ? '0 : tblMem.read_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            init_ptr_q  <= '0;
            hw_rvalid_q <= 1'b0;
            hw_rerr_q   <= 1'b0;
            hw_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            hw_rvalid_q <= hw_rvalid_d;
            hw_rerr_q   <= hw_rerr_d;
            hw_rdata_q  <= hw_rdata_d;
        end
    end

    assign tblMem.enable     = tbl_en;
    assign tblMem.wr_en      = tbl_wr;
    assign tblMem.addr       = tbl_addr;
    assign tblMem.write_data = tbl_wdata;
    assign regMem.read_data  = tblMem.read_data;

    assign hw_rvalid = hw_rvalid_q;
    assign hw_rdata  = hw_rdata_d;
    assign init_busy = (state_q == S_INIT);

`ifdef TBL_ARB_STATS_EN
    tbl_arb_sat_cnt #(.W(16)) u_cnt_gnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (init_req),
        .inc   (hw_gnt),
        .cnt   (stat_hw_gnt)
    );

    tbl_arb_sat_cnt #(.W(16)) u_cnt_blocked (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (init_req),
        .inc   (hw_req & ~hw_gnt),
        .cnt   (stat_hw_blocked)
    );
`endif
endmodule
